// File: rtl/openloop_ramp_ctrl.sv
// rtl/openloop_ramp_ctrl.sv - start/stop ramp sequencer for the open-loop drive chain
// Optional feature macro: SOFT_STOP_EN (ramped stop through RAMP_DOWN instead of an immediate stop)
module openloop_ramp_ctrl #(
  parameter int prescaler_width = 12,
  parameter int vector_width    = 16,
  parameter int tick_div_width  = 16
) (
  input  logic                       aclk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       fault,
  input  logic [tick_div_width-1:0]  tick_div,
  input  logic [prescaler_width-1:0] prescaler_start,
  input  logic [prescaler_width-1:0] prescaler_target,
  input  logic [vector_width-1:0]    d_start,
  input  logic [vector_width-1:0]    d_target,
  input  logic [vector_width-1:0]    d_step,
  output logic [prescaler_width-1:0] angle_prescaler,
  output logic [vector_width-1:0]    d_vector,
  output logic                       pwm_enable,
  output logic                       at_speed,
  output logic                       fault_latched,
  output logic [2:0]                 state
);

  localparam logic [2:0] st_idle      = 3'd0;
  localparam logic [2:0] st_ramp_up   = 3'd1;
  localparam logic [2:0] st_run       = 3'd2;
  localparam logic [2:0] st_ramp_down = 3'd3;
  localparam logic [2:0] st_fault     = 3'd4;

  localparam logic [prescaler_width-1:0] p_one    = 1;
  localparam logic [tick_div_width-1:0]  tick_one = 1;
  localparam logic [vector_width-1:0]    d_max    = {1'b0, {(vector_width-1){1'b1}}};

  logic [tick_div_width-1:0]  tick_cnt;
  logic [tick_div_width-1:0]  tick_last;
  logic                       ramping;
  logic                       step;

  logic [vector_width-1:0]    d_target_clamped;
  logic [vector_width:0]      d_up_sum;
  logic [vector_width-1:0]    d_up;
  logic [prescaler_width-1:0] p_up;
  logic                       up_reached;

  logic [2:0]                 state_nxt;
  logic [prescaler_width-1:0] ap_nxt;
  logic [vector_width-1:0]    d_nxt;
  logic                       pwm_nxt;
  logic [tick_div_width-1:0]  cnt_nxt;

  // A tick_div of zero behaves as one step per clock.
  assign tick_last = (tick_div == '0) ? '0 : tick_div - tick_one;
  assign ramping   = (state == st_ramp_up) || (state == st_ramp_down);
  assign step      = ramping && (tick_cnt >= tick_last);

  assign d_target_clamped = (d_target > d_max) ? d_max : d_target;
  assign d_up_sum   = {1'b0, d_vector} + {1'b0, d_step};
  assign d_up       = (d_up_sum > {1'b0, d_target_clamped}) ? d_target_clamped
                                                            : d_up_sum[vector_width-1:0];
  assign p_up       = (angle_prescaler > prescaler_target) ? angle_prescaler - p_one
                                                           : angle_prescaler;
  assign up_reached = (p_up <= prescaler_target) && (d_up >= d_target_clamped);

`ifdef SOFT_STOP_EN
  logic [vector_width-1:0]    d_diff;
  logic [vector_width-1:0]    d_down;
  logic [prescaler_width-1:0] p_down;
  logic                       down_reached;

  assign d_diff       = (d_vector >= d_step) ? d_vector - d_step : '0;
  assign d_down       = (d_diff > d_start) ? d_diff : d_start;
  assign p_down       = (angle_prescaler < prescaler_start) ? angle_prescaler + p_one
                                                            : angle_prescaler;
  assign down_reached = (p_down >= prescaler_start) && (d_down <= d_start);
`endif

  always_comb begin
    state_nxt = state;
    ap_nxt    = angle_prescaler;
    d_nxt     = d_vector;
    pwm_nxt   = pwm_enable;
    if (ramping) begin
      cnt_nxt = step ? '0 : tick_cnt + tick_one;
    end else begin
      cnt_nxt = '0;
    end

    if (fault) begin
      state_nxt = st_fault;
      ap_nxt    = '1;
      d_nxt     = '0;
      pwm_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        st_idle: begin
          if (start && !stop) begin
            state_nxt = st_ramp_up;
            ap_nxt    = prescaler_start;
            d_nxt     = d_start;
            pwm_nxt   = 1'b1;
            cnt_nxt   = '0;
          end
        end

        st_ramp_up, st_run: begin
          if (stop) begin
`ifdef SOFT_STOP_EN
            state_nxt = st_ramp_down;
            cnt_nxt   = '0;
`else
            state_nxt = st_idle;
            ap_nxt    = '1;
            d_nxt     = '0;
            pwm_nxt   = 1'b0;
            cnt_nxt   = '0;
`endif
          end else if (state == st_ramp_up && step) begin
            // RUN is decided from the post-step values so it lands with the last step.
            ap_nxt = p_up;
            d_nxt  = d_up;
            if (up_reached) begin
              state_nxt = st_run;
            end
          end
        end

`ifdef SOFT_STOP_EN
        st_ramp_down: begin
          if (start && !stop) begin
            state_nxt = st_ramp_up;
            cnt_nxt   = '0;
          end else if (step) begin
            if (down_reached) begin
              state_nxt = st_idle;
              ap_nxt    = '1;
              d_nxt     = '0;
              pwm_nxt   = 1'b0;
            end else begin
              ap_nxt = p_down;
              d_nxt  = d_down;
            end
          end
        end
`endif

        st_fault: begin
          if (start) begin
            state_nxt = st_idle;
            ap_nxt    = '1;
            d_nxt     = '0;
            pwm_nxt   = 1'b0;
          end
        end

        default: begin
          state_nxt = st_idle;
          ap_nxt    = '1;
          d_nxt     = '0;
          pwm_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state           <= st_idle;
      angle_prescaler <= '1;
      d_vector        <= '0;
      pwm_enable      <= 1'b0;
      at_speed        <= 1'b0;
      fault_latched   <= 1'b0;
      tick_cnt        <= '0;
    end else begin
      state           <= state_nxt;
      angle_prescaler <= ap_nxt;
      d_vector        <= d_nxt;
      pwm_enable      <= pwm_nxt;
      at_speed        <= (state_nxt == st_run);
      fault_latched   <= (state_nxt == st_fault);
      tick_cnt        <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_openloop_ramp_ctrl.sv
// tb/tb_openloop_ramp_ctrl.sv - directed scoreboard bench for openloop_ramp_ctrl
// Covers both builds; SOFT_STOP_EN selects the ramped-stop expectations.
module tb_openloop_ramp_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_UP    = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DOWN  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        fault = 1'b0;
  logic [15:0] tick_div;
  logic [11:0] prescaler_start;
  logic [11:0] prescaler_target;
  logic [15:0] d_start;
  logic [15:0] d_target;
  logic [15:0] d_step;
  logic [11:0] angle_prescaler;
  logic [15:0] d_vector;
  logic        pwm_enable;
  logic        at_speed;
  logic        fault_latched;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  st;
    logic [11:0] ap;
    logic [15:0] d;
    logic        pwm;
    logic        chk_ap;
  } exp_t;

  exp_t sb[$];

  openloop_ramp_ctrl dut (
    .aclk             (aclk),
    .resetn           (resetn),
    .start            (start),
    .stop             (stop),
    .fault            (fault),
    .tick_div         (tick_div),
    .prescaler_start  (prescaler_start),
    .prescaler_target (prescaler_target),
    .d_start          (d_start),
    .d_target         (d_target),
    .d_step           (d_step),
    .angle_prescaler  (angle_prescaler),
    .d_vector         (d_vector),
    .pwm_enable       (pwm_enable),
    .at_speed         (at_speed),
    .fault_latched    (fault_latched),
    .state            (state)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] st, input logic [11:0] ap, input logic [15:0] d,
                          input logic pwm, input logic chk_ap);
    exp_t e;
    e.st = st;
    e.ap = ap;
    e.d = d;
    e.pwm = pwm;
    e.chk_ap = chk_ap;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    logic [33:0] obs;
    logic [33:0] req;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty observed st=%0d", tag, state);
      return;
    end
    e = sb.pop_front();
    obs = {state, (e.chk_ap ? angle_prescaler : 12'h000), d_vector, pwm_enable, at_speed, fault_latched};
    req = {e.st, (e.chk_ap ? e.ap : 12'h000), e.d, e.pwm, (e.st == S_RUN), (e.st == S_FAULT)};
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed st=%0d ap=%0d d=%h pwm=%b as=%b fl=%b required st=%0d ap=%0d d=%h pwm=%b as=%b fl=%b",
             tag, state, angle_prescaler, d_vector, pwm_enable, at_speed, fault_latched,
             e.st, e.ap, e.d, e.pwm, (e.st == S_RUN), (e.st == S_FAULT));
    end
  endtask

  task automatic cfg_std();
    tick_div = 16'd4;
    prescaler_start = 12'd1000;
    prescaler_target = 12'd990;
    d_start = 16'h1000;
    d_target = 16'h4000;
    d_step = 16'h0800;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int p;
    int d;
    cfg_std();
    #12;
    push_exp(S_IDLE, 12'hFFF, 16'h0000, 1'b0, 1'b1);
    check_out("reset_state");
    resetn = 1'b1;
    tick();

    // Standard ramp up: 10 prescaler steps, d saturates at step 6.
    push_exp(S_UP, 12'd1000, 16'h1000, 1'b1, 1'b1);
    pulse_start();
    check_out("t2_entry");
    for (int k = 1; k <= 10; k++) begin
      p = (1000 - k < 990) ? 990 : 1000 - k;
      d = (16'h1000 + k * 16'h0800 > 16'h4000) ? 16'h4000 : 16'h1000 + k * 16'h0800;
      push_exp((k == 10) ? S_RUN : S_UP, p[11:0], d[15:0], 1'b1, 1'b1);
      repeat (4) tick();
      check_out($sformatf("t2_step%0d", k));
    end
    prescaler_target = 12'd900;
    d_target = 16'h7000;
    push_exp(S_RUN, 12'd990, 16'h4000, 1'b1, 1'b1);
    repeat (8) tick();
    check_out("t2_run_hold");
    cfg_std();

    // Stop from RUN.
`ifdef SOFT_STOP_EN
    push_exp(S_DOWN, 12'd990, 16'h4000, 1'b1, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_out("t3_down_entry");
    for (int k = 1; k <= 10; k++) begin
      p = (990 + k > 1000) ? 1000 : 990 + k;
      d = (16'h4000 - k * 16'h0800 < 16'h1000) ? 16'h1000 : 16'h4000 - k * 16'h0800;
      if (k == 10) push_exp(S_IDLE, 12'hFFF, 16'h0000, 1'b0, 1'b1);
      else push_exp(S_DOWN, p[11:0], d[15:0], 1'b1, 1'b1);
      repeat (4) tick();
      check_out($sformatf("t3_down_step%0d", k));
    end
`else
    push_exp(S_IDLE, 12'hFFF, 16'h0000, 1'b0, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_out("t3_hard_stop");
`endif

    // Stop part-way through RAMP_UP (and reversal when the ramped stop exists).
    push_exp(S_UP, 12'd1000, 16'h1000, 1'b1, 1'b1);
    pulse_start();
    check_out("t6_entry");
    push_exp(S_UP, 12'd995, 16'h3800, 1'b1, 1'b1);
    repeat (20) tick();
    check_out("t6_step5");
`ifdef SOFT_STOP_EN
    push_exp(S_DOWN, 12'd995, 16'h3800, 1'b1, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_out("t6_down_entry");
    push_exp(S_DOWN, 12'd997, 16'h2800, 1'b1, 1'b1);
    repeat (8) tick();
    check_out("t6_down_step2");
    push_exp(S_UP, 12'd997, 16'h2800, 1'b1, 1'b1);
    pulse_start();
    check_out("t6_reverse");
    for (int k = 1; k <= 7; k++) begin
      p = 997 - k;
      d = (16'h2800 + k * 16'h0800 > 16'h4000) ? 16'h4000 : 16'h2800 + k * 16'h0800;
      push_exp((k == 7) ? S_RUN : S_UP, p[11:0], d[15:0], 1'b1, 1'b1);
      repeat (4) tick();
      check_out($sformatf("t6_resume%0d", k));
    end
`else
    push_exp(S_IDLE, 12'hFFF, 16'h0000, 1'b0, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_out("t6_hard_stop_ramp");
`endif

    push_exp(S_FAULT, 12'h000, 16'h0000, 1'b0, 1'b0);
    fault = 1'b1;
    tick();
    fault = 1'b0;
    check_out("fault_enter");
    push_exp(S_IDLE, 12'hFFF, 16'h0000, 1'b0, 1'b1);
    pulse_start();
    check_out("fault_clear");

    // Fault at step 3 of RAMP_UP.
    push_exp(S_UP, 12'd1000, 16'h1000, 1'b1, 1'b1);
    pulse_start();
    check_out("t4_entry");
    push_exp(S_UP, 12'd997, 16'h2800, 1'b1, 1'b1);
    repeat (12) tick();
    check_out("t4_step3");
    push_exp(S_FAULT, 12'h000, 16'h0000, 1'b0, 1'b0);
    fault = 1'b1;
    tick();
    check_out("t4_fault");
    push_exp(S_FAULT, 12'h000, 16'h0000, 1'b0, 1'b0);
    pulse_start();
    check_out("t4_start_while_fault");
    push_exp(S_FAULT, 12'h000, 16'h0000, 1'b0, 1'b0);
    fault = 1'b0;
    tick();
    check_out("t4_fault_held");
    push_exp(S_IDLE, 12'hFFF, 16'h0000, 1'b0, 1'b1);
    pulse_start();
    check_out("t4_to_idle");
    push_exp(S_UP, 12'd1000, 16'h1000, 1'b1, 1'b1);
    pulse_start();
    check_out("t4_restart");
    push_exp(S_FAULT, 12'h000, 16'h0000, 1'b0, 1'b0);
    fault = 1'b1;
    tick();
    fault = 1'b0;
    check_out("t4_fault2");
    push_exp(S_IDLE, 12'hFFF, 16'h0000, 1'b0, 1'b1);
    pulse_start();
    check_out("t4_idle2");

    // tick_div=0, start+stop together, d_target clamp.
    tick_div = 16'd0;
    prescaler_start = 12'd1000;
    prescaler_target = 12'd998;
    d_start = 16'h7000;
    d_target = 16'hFFFF;
    d_step = 16'h0800;
    push_exp(S_IDLE, 12'hFFF, 16'h0000, 1'b0, 1'b1);
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check_out("t5_start_stop");
    push_exp(S_UP, 12'd1000, 16'h7000, 1'b1, 1'b1);
    pulse_start();
    check_out("t5_entry");
    push_exp(S_UP, 12'd999, 16'h7800, 1'b1, 1'b1);
    tick();
    check_out("t5_step1");
    push_exp(S_RUN, 12'd998, 16'h7FFF, 1'b1, 1'b1);
    tick();
    check_out("t5_clamp_run");
    push_exp(S_RUN, 12'd998, 16'h7FFF, 1'b1, 1'b1);
    tick();
    check_out("t5_run_hold");

    // Asynchronous reset in RUN, away from any clock edge.
    #3;
    resetn = 1'b0;
    #1;
    push_exp(S_IDLE, 12'hFFF, 16'h0000, 1'b0, 1'b1);
    check_out("t1_async_reset");
    tick();
    resetn = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
